// File: rtl/encoder_token_serializer.sv
// Captures one encoder output frame on a valid pulse and streams it out one token per beat.
// Optional TOKEN_SER_DBUF_EN adds a shadow frame buffer so frames stream back to back.
module encoder_token_serializer #(
  parameter int unsigned SEQ_LEN   = 8,
  parameter int unsigned EMBED_DIM = 32,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned IDX_W     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                valid_in,
  input  logic signed [SEQ_LEN-1:0][EMBED_DIM-1:0][DATA_W-1:0] y_in,
  output logic                                                in_ready,
  output logic                                                tok_valid,
  input  logic                                                tok_ready,
  output logic [EMBED_DIM*DATA_W-1:0]                         tok_data,
  output logic [IDX_W-1:0]                                    tok_idx,
  output logic                                                tok_last,
  output logic                                                frame_done,
  output logic                                                overflow,
  input  logic                                                clear_overflow
);

  localparam int unsigned TOK_W = EMBED_DIM * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

  typedef logic [SEQ_LEN-1:0][TOK_W-1:0] frame_t;
  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state;
  frame_t           frame_q;
  frame_t           y_frame_c;
  logic             hs_c;
  logic             last_hs_c;
  logic             take_c;
  logic [IDX_W-1:0] idx_nx_c;

  // Token d of a frame row occupies bits [d*DATA_W +: DATA_W]; a plain repack, sign bits copied.
  assign y_frame_c = frame_t'(y_in);
  assign hs_c      = tok_valid && tok_ready;
  assign last_hs_c = hs_c && tok_last;
  assign take_c    = valid_in && in_ready;
  assign idx_nx_c  = tok_idx + IDX_W'(1);

`ifdef TOKEN_SER_DBUF_EN
  frame_t shadow_q;
  logic   shadow_full;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      frame_q    <= '0;
      tok_valid  <= 1'b0;
      tok_data   <= '0;
      tok_idx    <= '0;
      tok_last   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      in_ready   <= 1'b1;
`ifdef TOKEN_SER_DBUF_EN
      shadow_q    <= '0;
      shadow_full <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;

      // Sticky drop flag; a new drop outranks a same-cycle clear.
      if (valid_in && !in_ready) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (take_c) begin
            frame_q   <= y_frame_c;
            tok_data  <= y_frame_c[0];
            tok_idx   <= '0;
            tok_last  <= (LAST_IDX == '0);
            tok_valid <= 1'b1;
            state     <= STREAM;
`ifndef TOKEN_SER_DBUF_EN
            in_ready  <= 1'b0;
`endif
          end
        end

        STREAM: begin
`ifdef TOKEN_SER_DBUF_EN
          // A frame arriving mid-stream parks in the shadow; on the last beat it bypasses instead.
          if (take_c && !last_hs_c) begin
            shadow_q    <= y_frame_c;
            shadow_full <= 1'b1;
            in_ready    <= 1'b0;
          end
`endif
          if (hs_c && !tok_last) begin
            tok_idx  <= idx_nx_c;
            tok_data <= frame_q[idx_nx_c];
            tok_last <= (idx_nx_c == LAST_IDX);
          end else if (last_hs_c) begin
            frame_done <= 1'b1;
`ifdef TOKEN_SER_DBUF_EN
            if (shadow_full) begin
              frame_q     <= shadow_q;
              tok_data    <= shadow_q[0];
              tok_idx     <= '0;
              tok_last    <= (LAST_IDX == '0);
              shadow_full <= 1'b0;
              in_ready    <= 1'b1;
            end else if (take_c) begin
              frame_q  <= y_frame_c;
              tok_data <= y_frame_c[0];
              tok_idx  <= '0;
              tok_last <= (LAST_IDX == '0);
            end else begin
              tok_valid <= 1'b0;
              tok_idx   <= '0;
              tok_last  <= 1'b0;
              state     <= IDLE;
            end
`else
            tok_valid <= 1'b0;
            tok_idx   <= '0;
            tok_last  <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_token_serializer.sv
// Directed bench for encoder_token_serializer: streaming, stalls, sign, overflow, reset.
module tb_encoder_token_serializer;

  localparam int unsigned SEQ_LEN   = 8;
  localparam int unsigned EMBED_DIM = 32;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned TOK_W     = EMBED_DIM * DATA_W;
`ifdef TOKEN_SER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, valid_in, tok_ready, clear_overflow;
  logic signed [SEQ_LEN-1:0][EMBED_DIM-1:0][DATA_W-1:0] y_in;
  logic in_ready, tok_valid, tok_last, frame_done, overflow;
  logic [TOK_W-1:0] tok_data;
  logic [IDX_W-1:0] tok_idx;

  encoder_token_serializer #(
    .SEQ_LEN(SEQ_LEN), .EMBED_DIM(EMBED_DIM), .DATA_W(DATA_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .y_in(y_in), .in_ready(in_ready),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data), .tok_idx(tok_idx),
    .tok_last(tok_last), .frame_done(frame_done), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [DATA_W-1:0] fr [SEQ_LEN][EMBED_DIM];
  logic [TOK_W-1:0]  exp_pk  [SEQ_LEN];
  logic [TOK_W-1:0]  exp_cur [SEQ_LEN];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [TOK_W-1:0] obs, input logic [TOK_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_ramp(input int unsigned base);
    for (int s = 0; s < SEQ_LEN; s++)
      for (int d = 0; d < EMBED_DIM; d++)
        fr[s][d] = DATA_W'(base + s * EMBED_DIM + d);
  endtask

  // Drive fr onto y_in and build the expected token words from the same table.
  task automatic pack_frame();
    for (int s = 0; s < SEQ_LEN; s++) begin
      exp_pk[s] = '0;
      for (int d = 0; d < EMBED_DIM; d++) begin
        y_in[s][d] = fr[s][d];
        exp_pk[s][d*DATA_W +: DATA_W] = fr[s][d];
      end
    end
  endtask

  task automatic run_beats(input string tag, input int first, input int last);
    for (int b = first; b <= last; b++) begin
      chk($sformatf("%s_valid%0d", tag, b), TOK_W'(tok_valid), TOK_W'(1));
      chk($sformatf("%s_idx%0d", tag, b), TOK_W'(tok_idx), TOK_W'(b));
      chk($sformatf("%s_data%0d", tag, b), tok_data, exp_cur[b]);
      chk($sformatf("%s_last%0d", tag, b), TOK_W'(tok_last), TOK_W'(b == SEQ_LEN - 1));
      tick();
    end
  endtask

  int   got;
  bit   stalled;
  logic [TOK_W-1:0] held_d;
  logic [IDX_W-1:0] held_i;

  initial begin
    rst = 1'b1; valid_in = 1'b0; tok_ready = 1'b0; clear_overflow = 1'b0; y_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", TOK_W'(tok_valid), TOK_W'(0));
    chk("rst_data", tok_data, '0);
    chk("rst_idx", TOK_W'(tok_idx), TOK_W'(0));
    chk("rst_last", TOK_W'(tok_last), TOK_W'(0));
    chk("rst_done", TOK_W'(frame_done), TOK_W'(0));
    chk("rst_ovf", TOK_W'(overflow), TOK_W'(0));
    chk("rst_ready", TOK_W'(in_ready), TOK_W'(1));

    // Basic frame, consumer always ready.
    fill_ramp(0); pack_frame(); exp_cur = exp_pk;
    valid_in = 1'b1; tok_ready = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("b_inready", TOK_W'(in_ready), TOK_W'(DBUF));
    chk("b_done0", TOK_W'(frame_done), TOK_W'(0));
    run_beats("b", 0, 2);
    chk("b_w35", TOK_W'(tok_data[5*DATA_W +: DATA_W]), TOK_W'(101));
    run_beats("b", 3, 7);
    chk("b_done", TOK_W'(frame_done), TOK_W'(1));
    chk("b_vend", TOK_W'(tok_valid), TOK_W'(0));
    chk("b_rdyend", TOK_W'(in_ready), TOK_W'(1));
    tick();
    chk("b_done_pulse", TOK_W'(frame_done), TOK_W'(0));

    // Ready pattern 1,0,0,1: data must hold during stalls, tokens in order.
    tok_ready = 1'b0; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    got = 0; stalled = 1'b0;
    for (int c = 0; c < 64 && got < SEQ_LEN; c++) begin
      if (stalled) begin
        chk("st_hold_data", tok_data, held_d);
        chk("st_hold_idx", TOK_W'(tok_idx), TOK_W'(held_i));
      end
      tok_ready = (c % 4 == 0) || (c % 4 == 3);
      if (tok_valid && tok_ready) begin
        chk($sformatf("st_idx%0d", got), TOK_W'(tok_idx), TOK_W'(got));
        chk($sformatf("st_data%0d", got), tok_data, exp_cur[got]);
        got++;
        stalled = 1'b0;
      end else begin
        stalled = tok_valid;
        held_d = tok_data;
        held_i = tok_idx;
      end
      tick();
    end
    chk("st_count", TOK_W'(got), TOK_W'(SEQ_LEN));
    chk("st_done", TOK_W'(frame_done), TOK_W'(1));
    tok_ready = 1'b1;

    // Second frame offered at beat 4, then set/clear collision, then plain clear.
    fill_ramp(0); pack_frame(); exp_cur = exp_pk;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    run_beats("ov", 0, 3);
    fill_ramp(16'h4000); pack_frame();
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("ov_flag", TOK_W'(overflow), TOK_W'(!DBUF));
    run_beats("ov", 5, 5);
    valid_in = 1'b1; clear_overflow = 1'b1;
    run_beats("ov", 6, 6);
    valid_in = 1'b0; clear_overflow = 1'b0;
    chk("ov_set_wins", TOK_W'(overflow), TOK_W'(1));
    clear_overflow = 1'b1;
    run_beats("ov", 7, 7);
    clear_overflow = 1'b0;
    chk("ov_cleared", TOK_W'(overflow), TOK_W'(0));
    chk("ov_done", TOK_W'(frame_done), TOK_W'(1));
    if (DBUF) begin
      exp_cur = exp_pk;
      run_beats("ov2", 0, 7);
      chk("ov2_done", TOK_W'(frame_done), TOK_W'(1));
    end
    chk("ov_vend", TOK_W'(tok_valid), TOK_W'(0));
    chk("ov_rdyend", TOK_W'(in_ready), TOK_W'(1));

    // Reset at beat 2 discards the frame.
    fill_ramp(0); pack_frame(); exp_cur = exp_pk;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    run_beats("rs", 0, 1);
    chk("rs_idx2", TOK_W'(tok_idx), TOK_W'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_valid", TOK_W'(tok_valid), TOK_W'(0));
    chk("rs_idx", TOK_W'(tok_idx), TOK_W'(0));
    chk("rs_ovf", TOK_W'(overflow), TOK_W'(0));
    chk("rs_ready", TOK_W'(in_ready), TOK_W'(1));

    // Fresh frame after reset carries negative extremes.
    fill_ramp(0);
    fr[2][31] = 16'h8000;
    fr[0][0]  = 16'hFFFF;
    pack_frame(); exp_cur = exp_pk;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("neg_w0", TOK_W'(tok_data[DATA_W-1:0]), TOK_W'(16'hFFFF));
    run_beats("neg", 0, 1);
    chk("neg_w31", TOK_W'(tok_data[31*DATA_W +: DATA_W]), TOK_W'(16'h8000));
    run_beats("neg", 2, 7);
    chk("neg_done", TOK_W'(frame_done), TOK_W'(1));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
